// File: rtl/ecualizador_control.sv
// Three-band equalizer sequencer: latches a sample, enables the filter bank,
// waits for it to settle, then applies per-band gains through one shared
// multiplier and presents a saturated, equalized sample.
module ecualizador_control #(
    parameter int unsigned ancho    = 25,
    parameter int unsigned fraccion = 16,
    parameter int unsigned LAT      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             muestra_ok,
    input  logic [ancho-1:0] muestra_in,
    input  logic [ancho-1:0] g_bajos,
    input  logic [ancho-1:0] g_medios,
    input  logic [ancho-1:0] g_altos,
    input  logic [ancho-1:0] ykbajos,
    input  logic [ancho-1:0] ykmedios,
    input  logic [ancho-1:0] ykaltos,
    output logic [ancho-1:0] x_filtro,
    output logic             en,
    output logic [ancho-1:0] salida,
    output logic             salida_ok,
    output logic             sat,
    output logic             ocupado,
    output logic             overrun
);

    localparam int unsigned PW = 2 * ancho;
    localparam int unsigned AW = 2 * ancho - fraccion + 2;
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    // Saturation limits, sign-extended to accumulator width
    localparam logic signed [AW-1:0] ACC_MAX = {{(AW-ancho+1){1'b0}}, {(ancho-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW-ancho+1){1'b1}}, {(ancho-1){1'b0}}};
    localparam logic [ancho-1:0]     OUT_MAX = {1'b0, {(ancho-1){1'b1}}};
    localparam logic [ancho-1:0]     OUT_MIN = {1'b1, {(ancho-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ESPERA = 3'd1,
        S_MUL0   = 3'd2,
        S_MUL1   = 3'd3,
        S_MUL2   = 3'd4,
        S_SAT    = 3'd5
    } estado_t;

    estado_t                state_q, state_d;
    logic [ancho-1:0]       x_q, x_d;
    logic                   en_q, en_d;
    logic [ancho-1:0]       sal_q, sal_d;
    logic                   sok_q, sok_d;
    logic                   sat_q, sat_d;
    logic                   ocup_q, ocup_d;
    logic                   ovr_q, ovr_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [ancho-1:0]       gb_q, gb_d, gm_q, gm_d, ga_q, ga_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [ancho-1:0]       op_y, op_g;
    logic signed [PW-1:0]   y_ext, g_ext, prod;
    logic signed [AW-1:0]   term;

    // Operand select for the shared multiplier, by band
    always_comb begin
        op_y = ykbajos;
        op_g = gb_q;
        unique case (state_q)
            S_MUL1:  begin op_y = ykmedios; op_g = gm_q; end
            S_MUL2:  begin op_y = ykaltos;  op_g = ga_q; end
            default: begin op_y = ykbajos;  op_g = gb_q; end
        endcase
    end

    // Full-width signed product, floored back to the fixed-point scale
    assign y_ext = {{ancho{op_y[ancho-1]}}, op_y};
    assign g_ext = {{ancho{op_g[ancho-1]}}, op_g};
    assign prod  = y_ext * g_ext;
    assign term  = AW'(prod >>> fraccion);

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        en_d    = 1'b0;
        sal_d   = sal_q;
        sok_d   = 1'b0;
        sat_d   = sat_q;
        ovr_d   = ovr_q;
        acc_d   = acc_q;
        gb_d    = gb_q;
        gm_d    = gm_q;
        ga_d    = ga_q;
        cnt_d   = cnt_q;

        if (muestra_ok && (state_q != S_IDLE)) begin
            ovr_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (muestra_ok) begin
                    x_d     = muestra_in;
                    gb_d    = g_bajos;
                    gm_d    = g_medios;
                    ga_d    = g_altos;
                    acc_d   = '0;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    state_d = S_ESPERA;
                end
            end
            S_ESPERA: begin
                if (cnt_q == CW'(LAT - 1)) begin
                    state_d = S_MUL0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MUL0: begin
                acc_d   = acc_q + term;
                state_d = S_MUL1;
            end
            S_MUL1: begin
                acc_d   = acc_q + term;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                acc_d   = acc_q + term;
                state_d = S_SAT;
            end
            S_SAT: begin
                if (acc_q > ACC_MAX) begin
                    sal_d = OUT_MAX;
                    sat_d = 1'b1;
                end else if (acc_q < ACC_MIN) begin
                    sal_d = OUT_MIN;
                    sat_d = 1'b1;
                end else begin
                    sal_d = acc_q[ancho-1:0];
                    sat_d = 1'b0;
                end
                sok_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ocup_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            en_q    <= 1'b0;
            sal_q   <= '0;
            sok_q   <= 1'b0;
            sat_q   <= 1'b0;
            ocup_q  <= 1'b0;
            ovr_q   <= 1'b0;
            acc_q   <= '0;
            gb_q    <= '0;
            gm_q    <= '0;
            ga_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            en_q    <= en_d;
            sal_q   <= sal_d;
            sok_q   <= sok_d;
            sat_q   <= sat_d;
            ocup_q  <= ocup_d;
            ovr_q   <= ovr_d;
            acc_q   <= acc_d;
            gb_q    <= gb_d;
            gm_q    <= gm_d;
            ga_q    <= ga_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x_filtro  = x_q;
    assign en        = en_q;
    assign salida    = sal_q;
    assign salida_ok = sok_q;
    assign sat       = sat_q;
    assign ocupado   = ocup_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/ecualizador_control.md
# ecualizador_control

Sequencer for the three-band equalizer datapath. On each accepted audio sample it latches the sample and pulses `en` to the band-split filter bank. It waits a fixed settling interval, then time-shares one signed multiplier across the low, mid and high band outputs to apply per-band gains. It accumulates the three products, saturates the sum, and presents one equalized sample with a valid strobe.

## Interface
- `ancho`, 25: sample, coefficient and gain word width; signed fixed point, `fraccion` fractional bits.
- `fraccion`, 16: fractional bits; 1.0 = 25'h0010000.
- `LAT`, 2: cycles waited after the `en` pulse before the filter outputs are read; ≥1.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `muestra_ok`  in  1  single-cycle strobe: new sample present on `muestra_in`.
- `muestra_in`  in  ancho  signed input sample.
- `g_bajos`, `g_medios`, `g_altos`  in  ancho each  signed band gains.
- `ykbajos`, `ykmedios`, `ykaltos`  in  ancho each  signed filter-bank band outputs.
- `x_filtro`  out  ancho  registered sample driving the filter bank input.
- `en`  out  1  one-cycle filter-bank enable pulse.
- `salida`  out  ancho  equalized output sample, held until the next update.
- `salida_ok`  out  1  one-cycle valid strobe for `salida`.
- `sat`  out  1  clip flag; updates together with `salida`.
- `ocupado`  out  1  high whenever the FSM is not in IDLE.
- `overrun`  out  1  sticky flag: a strobe arrived while busy.

## Operation
- **Reset (asynchronous, `reset`=0):**
  - State goes to IDLE.
  - `x_filtro`, `salida`, accumulator, gain latches and counter go to 0.
  - `en`, `salida_ok`, `sat`, `overrun` go to 0.
  - Any in-flight sample is discarded with no `salida_ok`.
- **FSM states:** IDLE → ESPERA → MUL0 → MUL1 → MUL2 → SAT → IDLE.
- **IDLE:**
  - On `muestra_ok`=1: load `x_filtro`←`muestra_in`.
  - Latch all three gains.
  - Clear the accumulator and the wait counter.
  - Set `en`←1 and go to ESPERA.
- **ESPERA:**
  - `en` is forced back to 0 after one cycle.
  - Counter runs for LAT cycles, then go to MUL0.
- **MUL0 / MUL1 / MUL2:** accumulate one band per cycle.
  - MUL0: acc += `ykbajos`·gain_bajos.
  - MUL1: acc += `ykmedios`·gain_medios.
  - MUL2: acc += `ykaltos`·gain_altos.
  - One shared multiplier, operands selected by state.
- **Product arithmetic:**
  - Full-width signed product, 2·ancho bits.
  - Arithmetic shift right by `fraccion`, i.e. truncation toward −∞.
  - Sign-extend into a (2·ancho−fraccion+2)-bit accumulator.
- **SAT:**
  - If acc > 2^(ancho−1)−1: `salida`←25'h0FFFFFF, `sat`←1.
  - If acc < −2^(ancho−1): `salida`←25'h1000000, `sat`←1.
  - Otherwise `salida`←acc[ancho−1:0], `sat`←0.
  - Set `salida_ok`←1 and return to IDLE.
- **Strobe while busy:** `muestra_ok` in any state other than IDLE is dropped.
  - `overrun`←1; it stays set until reset.
  - The in-flight sample continues unaffected.
- **Simultaneous strobe in the SAT cycle:** dropped and flagged. The new sample is accepted only if the strobe arrives in IDLE.
- **Gains:** values are used only as latched at acceptance. Changes to the gain inputs during processing do not affect the current sample.
- **`ocupado`:** registered; high from the cycle after acceptance through SAT.

## Timing
- Cycle 0 is the IDLE cycle with `muestra_ok`=1.
- `en`=1 and the new `x_filtro` are valid in cycle 1 only for `en`; `x_filtro` holds until the next acceptance.
- ESPERA occupies cycles 1..LAT.
- MUL0, MUL1, MUL2 occupy cycles LAT+1, LAT+2, LAT+3.
- SAT occupies cycle LAT+4.
- `salida_ok`=1 and the new `salida`/`sat` are valid in cycle LAT+5; `salida_ok` is high for exactly one cycle.
- Minimum strobe spacing without overrun: LAT+5 cycles. A strobe in cycle LAT+5 (state IDLE) is accepted.
- Filter outputs are sampled in MUL cycles only, so the filter bank must settle within LAT cycles of `en`.

## Test plan
- **Path check:** LAT=2, all gains 25'h0010000, yk = 25'h0008000 / 25'h0004000 / 25'h0002000, strobe at cycle 0.
  - Required: `salida`=25'h000E000, `sat`=0, `salida_ok` high only in cycle 7.
- **Enable/capture:** `muestra_in`=25'h0001234 with strobe.
  - Required: `x_filtro`=25'h0001234 from cycle 1; `en` high in cycle 1 only; `ocupado` high cycles 1–6.
- **Saturation:** all yk=25'h0640000 (100.0), gains 1.0.
  - Required: `salida`=25'h0FFFFFF, `sat`=1.
  - Repeat with yk=25'h19C0000 (−100.0): required `salida`=25'h1000000, `sat`=1.
- **Truncation:** ykbajos=25'h1FFFFFF (−1 LSB), g_bajos=25'h0008000 (0.5), other gains 0.
  - Required: `salida`=25'h1FFFFFF.
- **Overrun and gain latch:**
  - Second strobe at cycle 3 → ignored, `overrun`=1 and held.
  - g_bajos changed at cycle 2 → the first result uses the old gain.
  - A strobe at cycle 7 (IDLE) is accepted normally.
- **Reset mid-operation:** assert `reset`=0 during cycle LAT+2.
  - Required: all outputs 0 immediately; no `salida_ok`.
  - After release, the next strobe produces a correct result.
